// File: rtl/cpu_pkg.sv
// Shared types and instruction-field constants for the LEGv8 fetch stage.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned IMM26_MSB = 25;
    localparam int unsigned IMM26_LSB = 0;
    localparam int unsigned IMM19_MSB = 23;
    localparam int unsigned IMM19_LSB = 5;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_unit_br_target.sv
// Next-PC computation: sequential increment or PC-relative B / B.cond target.
module br_target
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               brtaken,
    input  logic               uncondbr,
    output logic [ADDR_W-1:0]  next_pc
);

    localparam int unsigned IMM26_W = IMM26_MSB - IMM26_LSB + 1;
    localparam int unsigned IMM19_W = IMM19_MSB - IMM19_LSB + 1;

    logic [ADDR_W-1:0] off26;
    logic [ADDR_W-1:0] off19;
    logic              unused_opcode;

    assign unused_opcode = ^instruction[INSTR_W-1:IMM26_MSB+1];

    always_comb begin
        off26 = {{(ADDR_W-IMM26_W){instruction[IMM26_MSB]}}, instruction[IMM26_MSB:IMM26_LSB]};
        off19 = {{(ADDR_W-IMM19_W){instruction[IMM19_MSB]}}, instruction[IMM19_MSB:IMM19_LSB]};
        off26 = off26 << 2;
        off19 = off19 << 2;
        // brtaken is tested first so an unknown uncondbr cannot reach pc on the fall-through path
        if (brtaken) begin
            if (uncondbr) next_pc = pc + off26;
            else          next_pc = pc + off19;
        end else begin
            next_pc = pc + ADDR_W'(PC_INC);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch/PC stage: fetch FSM, PC and instruction registers, retire counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 64,
    parameter logic [63:0]     RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               brtaken,
    input  logic               uncondbr,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [31:0]        instr_count
);

    fetch_state_t      state, state_next;
    logic              load_instr;
    logic              retire;
    logic [ADDR_W-1:0] next_pc;

    br_target #(.ADDR_W(ADDR_W)) u_br_target (
        .pc          (pc),
        .instruction (instruction),
        .brtaken     (brtaken),
        .uncondbr    (uncondbr),
        .next_pc     (next_pc)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_instr  = 1'b0;
        retire      = 1'b0;
        unique case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= ADDR_W'(RESET_PC);
            instruction <= '0;
            instr_count <= '0;
        end else begin
            if (load_instr) instruction <= imem_rdata;
            if (retire) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a sparse memory and PC model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        brtaken;
    logic        uncondbr;
    logic        stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic [31:0] instr_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] mem [logic [63:0]];
    logic [63:0] exp_pc;
    logic [31:0] exp_count;

    fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .brtaken     (brtaken),
        .uncondbr    (uncondbr),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic get_word(input logic [63:0] a, output logic [31:0] w);
        if (!mem.exists(a)) mem[a] = $urandom;
        w = mem[a];
    endtask

    // Architectural next-PC: word offsets scaled by 4, wrapping modulo 2^64.
    function automatic logic [63:0] model_next(input logic [63:0] p, input logic [31:0] w,
                                               input logic bt, input logic ub);
        longint off;
        if (!bt)     off = 4;
        else if (ub) off = longint'($signed(w[25:0])) * 4;
        else         off = longint'($signed(w[23:5])) * 4;
        return p + 64'(off);
    endfunction

    // Entered with the DUT in FETCH; leaves it back in FETCH after one retire.
    task automatic run_instr(input int lat, input int nstall, input logic bt, input logic ub);
        logic [31:0] w;
        chk("fetch_req", 64'(imem_req), 64'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < lat; i++) begin
            imem_rvalid = 1'b0;
            step();
            chk("wait_req", 64'(imem_req), 64'd1);
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_ivalid", 64'(instr_valid), 64'd0);
        end
        get_word(exp_pc, w);
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk("exec_ivalid", 64'(instr_valid), 64'd1);
        chk("exec_req", 64'(imem_req), 64'd0);
        chk("exec_instr", 64'(instruction), 64'(w));
        chk("exec_pc", pc, exp_pc);
        for (int i = 0; i < nstall; i++) begin
            stall       = 1'b1;
            brtaken     = 1'($urandom);
            uncondbr    = 1'($urandom);
            imem_rvalid = 1'($urandom);
            step();
            chk("stall_pc", pc, exp_pc);
            chk("stall_instr", 64'(instruction), 64'(w));
            chk("stall_count", 64'(instr_count), 64'(exp_count));
            chk("stall_ivalid", 64'(instr_valid), 64'd1);
        end
        imem_rvalid = 1'b0;
        stall    = 1'b0;
        brtaken  = bt;
        uncondbr = ub;
        step();
        brtaken  = 1'b0;
        uncondbr = 1'b0;
        exp_pc    = model_next(exp_pc, w, bt, ub);
        exp_count = exp_count + 32'd1;
        chk("retire_pc", pc, exp_pc);
        chk("retire_count", 64'(instr_count), 64'(exp_count));
        chk("retire_ivalid", 64'(instr_valid), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        brtaken     = 1'b0;
        uncondbr    = 1'b0;
        stall       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        exp_pc      = 64'h0;
        exp_count   = 32'd0;

        mem[64'h00] = 32'h91000421;
        mem[64'h04] = 32'h14000003;   // B +3   -> 0x10
        mem[64'h10] = 32'h17FFFFFE;   // B -2   -> 0x08
        mem[64'h08] = 32'h540000C0;   // B.cond +6 -> 0x20
        mem[64'h20] = 32'h54000060;   // B.cond +3 -> 0x2C
        mem[64'h2C] = 32'h17FFFFFD;   // B -3   -> 0x20
        mem[64'h24] = 32'h14000007;   // B +7   -> 0x40

        step();
        step();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_pc", pc, 64'h0);
        chk("rst_instr", 64'(instruction), 64'h0);
        chk("rst_ivalid", 64'(instr_valid), 64'd0);
        chk("rst_count", 64'(instr_count), 64'd0);

        reset = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        #1;
        chk("boot_req", 64'(imem_req), 64'd0);
        step();
        imem_rvalid = 1'b0;
        chk("boot_instr_ignored", 64'(instruction), 64'h0);

        run_instr(0, 0, 1'b0, 1'b0);
        chk("first_pc", pc, 64'h4);
        run_instr(0, 0, 1'b1, 1'b1);
        run_instr(1, 0, 1'b1, 1'b1);
        chk("b_neg_pc", pc, 64'h08);
        run_instr(0, 0, 1'b1, 1'b0);
        run_instr(2, 0, 1'b1, 1'b0);
        chk("bcond_taken_pc", pc, 64'h2C);
        run_instr(0, 0, 1'b1, 1'b1);
        run_instr(0, 0, 1'b0, 1'b0);
        chk("bcond_nottaken_pc", pc, 64'h24);
        run_instr(0, 5, 1'b1, 1'b1);
        chk("stall_retire_pc", pc, 64'h40);

        for (int i = 0; i < 3; i++) begin
            step();
            chk("lat3_req", 64'(imem_req), 64'd1);
            chk("lat3_addr", imem_addr, 64'h40);
        end
        reset = 1'b1;
        #1;
        chk("midrst_pc", pc, 64'h0);
        chk("midrst_req", 64'(imem_req), 64'd0);
        step();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFEF00D;
        step();
        imem_rvalid = 1'b0;
        chk("late_rvalid_instr", 64'(instruction), 64'h0);
        chk("late_rvalid_ivalid", 64'(instr_valid), 64'd0);
        chk("late_rvalid_count", 64'(instr_count), 64'd0);
        chk("refetch_addr", imem_addr, 64'h0);
        exp_pc    = 64'h0;
        exp_count = 32'd0;

        mem[64'h0] = 32'h17FFFFFF;     // B -1 -> 2^64-4
        run_instr(0, 0, 1'b1, 1'b1);
        chk("wrap_top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        run_instr(0, 0, 1'b0, 1'bx);
        chk("wrap_zero_pc", pc, 64'h0);

        mem.delete();
        for (int n = 0; n < 200; n++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
